uart_rx_sequencer: RTL
======================

UART_RX_SEQUENCER -- requirements
Module: uart_rx_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200: line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal 5..9: data bits per frame.
REQ-004 SHALL have parameter STOP_BITS, default 1, legal 1..2: stop bits checked per frame.
REQ-005 SHALL have port CLOCK_50, input, 1 bit: the single clock, rising-edge active.
REQ-006 SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port RxD, input, 1 bit: asynchronous serial line, idle high.
REQ-008 SHALL have port Enable, input, 1 bit: when low, start-bit detection is inhibited; a frame in progress completes.
REQ-009 SHALL have port RShift, output, 1 bit: one-cycle pulse at the sample point of each data bit.
REQ-010 SHALL have port RxData, output, DATA_BITS bits: last received word, LSB received first.
REQ-011 SHALL have port DataValid, output, 1 bit: one-cycle pulse when a frame is accepted.
REQ-012 SHALL have port FrameErr, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-013 SHALL have port ParityErr, output, 1 bit: one-cycle pulse on a parity mismatch.
REQ-014 SHALL have port Busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL define HALF = CLK_HZ/(2*BAUD) using integer truncation, and BIT = 2*HALF cycles.
REQ-016 SHALL pass RxD through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-017 SHALL have FSM states IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE -> START when Enable=1 and rx_s falls 1->0; the timer loads 0.
REQ-019 In START, after HALF cycles, SHALL sample rx_s: if 0, go to DATA; if 1, treat as a false start and return to IDLE with no output pulses.
REQ-020 In DATA, SHALL sample rx_s every BIT cycles, shift it into bit DATA_BITS-1 of the shift register (right shift), and pulse RShift in the same cycle.
REQ-021 After DATA_BITS samples, SHALL go to PARITY (macro defined) or to STOP.
REQ-022 In STOP, SHALL sample rx_s after BIT cycles, once per stop bit; any 0 sample pulses FrameErr and returns to IDLE immediately.
REQ-023 When all stop bits read 1, SHALL copy the shift register to RxData and pulse DataValid in the cycle after the final stop sample, then return to IDLE.
REQ-024 RxData SHALL hold its value until the next accepted frame and SHALL NOT change on error frames.
REQ-025 The bit counter SHALL be ceil(log2(DATA_BITS+1)) bits wide and the timer ceil(log2(BIT+1)) bits wide; neither SHALL wrap within a frame.
REQ-026 DataValid, FrameErr and ParityErr SHALL be mutually exclusive in any cycle.
REQ-027 An RxD falling edge during STOP or during the DataValid cycle SHALL NOT be lost; back-to-back frames SHALL be received with no idle gap.
REQ-028 Enable going low mid-frame SHALL NOT abort the frame.

Reset
REQ-029 Reset=1 on a clock edge SHALL force IDLE, clear the timer, bit counter and shift register, set RxData=0, set RShift, DataValid, FrameErr, ParityErr and Busy to 0, and set the synchronizer flops to 1.
REQ-030 Reset mid-frame SHALL discard the partial frame with no pulses; reception resumes on the next falling edge after Reset is released.

Configuration
REQ-031 Macro UART_RX_PARITY_EN defined: SHALL add parameter PARITY_ODD (default 0 = even) and the PARITY state, which samples one bit BIT cycles after the last data sample.
REQ-032 With UART_RX_PARITY_EN defined, a parity mismatch SHALL pulse ParityErr in the cycle after the stop sample(s), withhold DataValid, and leave RxData unchanged.
REQ-033 Macro UART_RX_PARITY_EN undefined: no PARITY state, no parity bit in the frame, and ParityErr tied to 0.

Verification (CLK_HZ=1000, BAUD=50 -> HALF=10, BIT=20)
REQ-034 Send 0xA5, 8N1 -> RShift pulses exactly 8 times, 20 cycles apart; DataValid pulses once; RxData=8'hA5; FrameErr=0.
REQ-035 Hold RxD low for 5 cycles, then high -> START aborts, Busy returns to 0, no pulses, RxData unchanged.
REQ-036 Send 0x3C with stop bit=0 -> FrameErr pulses once, DataValid=0, RxData keeps its previous value.
REQ-037 Send 0x00 then 0xFF back-to-back with STOP_BITS=1 -> two DataValid pulses 200 cycles apart; RxData ends at 8'hFF.
REQ-038 Assert Reset for 1 cycle at data bit 4 of a frame -> all outputs 0, no DataValid; the following 0x5A frame is received correctly.
REQ-039 UART_RX_PARITY_EN defined, PARITY_ODD=0: send 0x07 with parity bit 0 -> ParityErr pulses once and DataValid does not; send 0x07 with parity bit 1 -> DataValid pulses and RxData=8'h07.

Source files
------------

// File: rtl/uart_rx_sequencer.sv
// UART receiver sequencer: 2-flop synchronized RxD, start/data/parity/stop sequencing with one-cycle status pulses.
// Optional parity stage is compiled in when UART_RX_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a falling edge on rx_s while Enable is high
// START  | wait HALF cycles, confirm start bit is still low
// DATA   | sample one data bit every BIT cycles, LSB first
// PARITY | sample the parity bit BIT cycles after the last data bit
// STOP   | sample each stop bit BIT cycles apart, then report the frame
module uart_rx_sequencer #(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 CLOCK_50,
    input  logic                 Reset,
    input  logic                 RxD,
    input  logic                 Enable,
    output logic                 RShift,
    output logic [DATA_BITS-1:0] RxData,
    output logic                 DataValid,
    output logic                 FrameErr,
    output logic                 ParityErr,
    output logic                 Busy
);

    localparam int HALF = CLK_HZ / (2 * BAUD);
    localparam int BIT  = 2 * HALF;
    localparam int TW   = $clog2(BIT + 1);
    localparam int BCW  = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0]  HALF_TC = TW'(HALF - 1);
    localparam logic [TW-1:0]  BIT_TC  = TW'(BIT - 1);
    localparam logic [BCW-1:0] DATA_TC = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] STOP_TC = BCW'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                 state, state_n;
    logic [1:0]             sync;
    logic                   rx_s, rx_prev;
    logic [TW-1:0]          timer, timer_n;
    logic [BCW-1:0]         bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0]   shreg, shreg_n, rx_data_n;
    logic                   dv_n, fe_n;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad, par_bad_n, pe_n;
`endif

    assign rx_s = sync[1];
    assign Busy = (state != IDLE);

    always_comb begin
        state_n   = state;
        timer_n   = timer + 1'b1;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        rx_data_n = RxData;
        dv_n      = 1'b0;
        fe_n      = 1'b0;
        RShift    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = par_bad;
        pe_n      = 1'b0;
`endif
        case (state)
            IDLE: begin
                timer_n   = '0;
                bit_cnt_n = '0;
                if (Enable && rx_prev && !rx_s)
                    state_n = START;
            end
            START: begin
                if (timer == HALF_TC) begin
                    timer_n = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer == BIT_TC) begin
                    timer_n = '0;
                    RShift  = 1'b1;
                    shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                    if (bit_cnt == DATA_TC) begin
                        bit_cnt_n = '0;
`ifdef UART_RX_PARITY_EN
                        state_n   = PARITY;
`else
                        state_n   = STOP;
`endif
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (timer == BIT_TC) begin
                    timer_n   = '0;
                    par_bad_n = (^shreg) ^ rx_s ^ PARITY_ODD;
                    state_n   = STOP;
                end
            end
`endif
            STOP: begin
                if (timer == BIT_TC) begin
                    timer_n = '0;
                    if (!rx_s) begin
                        fe_n    = 1'b1;
                        state_n = IDLE;
                    end else if (bit_cnt == STOP_TC) begin
                        state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad) begin
                            pe_n = 1'b1;
                        end else begin
                            dv_n      = 1'b1;
                            rx_data_n = shreg;
                        end
`else
                        dv_n      = 1'b1;
                        rx_data_n = shreg;
`endif
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Sync flops reset high so leaving reset never looks like a start edge on an idle line.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            sync      <= 2'b11;
            rx_prev   <= 1'b1;
            state     <= IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            RxData    <= '0;
            DataValid <= 1'b0;
            FrameErr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
            ParityErr <= 1'b0;
`endif
        end else begin
            sync      <= {sync[0], RxD};
            rx_prev   <= rx_s;
            state     <= state_n;
            timer     <= timer_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            RxData    <= rx_data_n;
            DataValid <= dv_n;
            FrameErr  <= fe_n;
`ifdef UART_RX_PARITY_EN
            par_bad   <= par_bad_n;
            ParityErr <= pe_n;
`endif
        end
    end

`ifndef UART_RX_PARITY_EN
    assign ParityErr = 1'b0;
`endif

endmodule
